round_timer_ctrl: RTL and testbench
===================================

ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

Interface
REQ-001 SHALL have parameter SCALE_RST, default 4'd9, the tens start value the countdown timer's scaling stage holds after reset.
REQ-002 SHALL have parameter MIN_TENS, default 4'd1, the lowest tens start value ever requested.
REQ-003 SHALL have parameter STEP_GAP, default 2, the cycle period between successive increment/decrement pulses (minimum 2).
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 start_round  input  1  one-cycle pulse from the game controller that begins a timed round.
REQ-007 round_done  input  1  one-cycle pulse: the player finished the sequence before time ran out.
REQ-008 level  input  4  current game level, sampled on start_round.
REQ-009 timeout  input  1  level signal from the countdown timer, high while it sits at 00.
REQ-010 ReConfig  output  1  high while the timer's start value is being adjusted and reloaded.
REQ-011 enable  output  1  high while the timer's one-second tick runs.
REQ-012 increment  output  1  one-cycle pulse: raise the timer's tens start value by 1.
REQ-013 decrement  output  1  one-cycle pulse: lower the timer's tens start value by 1.
REQ-014 time_up  output  1  one-cycle pulse: round lost on timeout.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, ADJUST, LOAD, RUN; all outputs registered.
REQ-017 SHALL hold a 4-bit shadow register of the timer's tens start value, reset to SCALE_RST and range-limited to MIN_TENS..9.
REQ-018 On start_round in any state SHALL latch target = 9 - level, clamped to MIN_TENS when level >= 9 - MIN_TENS, and enter ADJUST the next cycle.
REQ-019 In ADJUST SHALL hold ReConfig high. If shadow != target and the gap counter is 0, it SHALL pulse increment or decrement for one cycle, update shadow by 1 on that edge, and reload the gap counter to STEP_GAP-1. Otherwise it SHALL decrement the gap counter.
REQ-020 In ADJUST, once shadow == target, SHALL move to LOAD; with shadow == target at entry, ADJUST SHALL last exactly one cycle.
REQ-021 In LOAD SHALL hold ReConfig high for exactly one cycle so the timer reloads its digits, then enter RUN.
REQ-022 In RUN SHALL drive enable high and ReConfig, increment and decrement low.
REQ-023 SHALL never assert increment and decrement in the same cycle, nor either one outside ADJUST.
REQ-024 SHALL detect the timeout rising edge only in RUN: pulse time_up for one cycle, drop enable on the same edge, and return to IDLE.
REQ-025 In RUN, round_done SHALL drop enable and return to IDLE without asserting time_up.
REQ-026 round_done and timeout rising in the same cycle SHALL be resolved in favour of round_done, with no time_up.
REQ-027 start_round in the same cycle as round_done or timeout SHALL take priority: enter ADJUST, no time_up.
REQ-028 SHALL ignore round_done and timeout in IDLE, ADJUST and LOAD.
REQ-029 A start_round during ADJUST SHALL re-latch target and continue stepping from the current shadow value without resetting it.

Reset
REQ-030 Asserting rst SHALL immediately force state IDLE, shadow = SCALE_RST, gap counter = 0, and ReConfig, enable, increment, decrement, time_up and busy all 0.
REQ-031 Reset asserted mid-ADJUST SHALL discard the operation; the shadow returns to SCALE_RST, matching the timer's own reset.

Structure
REQ-032 The FSM state encoding and the constants MAX_TENS=9 and the SCALE_RST default SHALL live in the shared timer package also used by the timer blocks.
REQ-033 The gap counter plus pulse generation SHALL be one sub-module, step_pacer, with inputs clk, rst, active and dir_up, and outputs inc_pulse and dec_pulse.

Verification
REQ-034 Reset -> all outputs 0, busy 0, internal shadow 9.
REQ-035 start_round with level=3 from shadow 9 -> exactly 3 decrement pulses 2 cycles apart and no increment; ReConfig high from the cycle after start through LOAD; enable rises 2 cycles after the last pulse.
REQ-036 Shadow 6, start_round with level=12 -> target clamps to 1; exactly 5 decrement pulses; then RUN.
REQ-037 In RUN, timeout rises -> time_up high for exactly 1 cycle, enable low on the same edge, busy low next cycle; timeout held high afterwards -> no second time_up.
REQ-038 In RUN, round_done and timeout rise in the same cycle -> time_up stays 0 and enable drops; in a separate case, start_round with round_done -> ADJUST entered.
REQ-039 rst asserted asynchronously mid-ADJUST -> outputs 0 before the next clock edge; a following start_round with level=0 -> zero pulses, and LOAD on the second cycle.

Source files
------------

// File: rtl/round_timer_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | round_timer_ctrl_pkg                                             |
// | Shared timer definitions: controller states, tens limits and the |
// | start-value target calculation.                                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package round_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADJUST = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RUN    = 2'd3
  } round_state_t;

  localparam logic [3:0] MAX_TENS          = 4'd9;
  localparam logic [3:0] SCALE_RST_DEFAULT = 4'd9;

  // Higher levels get less time; never go below the configured floor.
  function automatic logic [3:0] tens_target(input logic [3:0] level,
                                             input logic [3:0] min_tens);
    if (level >= (MAX_TENS - min_tens)) begin
      return min_tens;
    end
    return MAX_TENS - level;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_timer_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | round_timer_ctrl_if                                              |
// | Game-controller / timer handshake bundle for round_timer_ctrl.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface round_timer_ctrl_if;
  logic       start_round;
  logic       round_done;
  logic [3:0] level;
  logic       timeout;
  logic       ReConfig;
  logic       enable;
  logic       increment;
  logic       decrement;
  logic       time_up;
  logic       busy;

  modport master (
    output start_round, round_done, level, timeout,
    input  ReConfig, enable, increment, decrement, time_up, busy
  );

  modport slave (
    input  start_round, round_done, level, timeout,
    output ReConfig, enable, increment, decrement, time_up, busy
  );
endinterface
`default_nettype wire

// File: rtl/step_pacer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_pacer                                                       |
// | Spaces increment/decrement steps STEP_GAP cycles apart. Pulses   |
// | are combinational; the caller registers them.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module step_pacer #(
  parameter int STEP_GAP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic dir_up,
  output logic inc_pulse,
  output logic dec_pulse
);

  localparam int GAP_W = (STEP_GAP > 2) ? $clog2(STEP_GAP) : 1;
  localparam logic [GAP_W-1:0] c_gap_reload = GAP_W'(STEP_GAP - 1);

  logic [GAP_W-1:0] r_gap;
  logic             w_fire;

  assign w_fire    = active && (r_gap == '0);
  assign inc_pulse = w_fire && dir_up;
  assign dec_pulse = w_fire && !dir_up;

  // Gap counter: idle at zero so the first step of a new adjust is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (!active) begin
      r_gap <= '0;
    end else if (w_fire) begin
      r_gap <= c_gap_reload;
    end else begin
      r_gap <= r_gap - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/round_timer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | round_timer_ctrl                                                 |
// | Round controller: steps the countdown timer's tens start value   |
// | toward a level-derived target, reloads it, then runs the round   |
// | until round_done or a timeout edge.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module round_timer_ctrl
  import round_timer_ctrl_pkg::*;
#(
  parameter logic [3:0] SCALE_RST = SCALE_RST_DEFAULT,
  parameter logic [3:0] MIN_TENS  = 4'd1,
  parameter int         STEP_GAP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  round_timer_ctrl_if.slave  ctl
);

  round_state_t r_state;
  round_state_t w_state_next;

  logic [3:0] r_shadow;
  logic [3:0] r_target;
  logic [3:0] w_target_new;
  logic [3:0] w_target_eff;
  logic       r_timeout_q;
  logic       w_timeout_rise;
  logic       w_step_active;
  logic       w_dir_up;
  logic       w_inc_pulse;
  logic       w_dec_pulse;

  logic       w_reconfig_next;
  logic       w_enable_next;
  logic       w_time_up_next;
  logic       w_busy_next;

  logic       r_reconfig;
  logic       r_enable;
  logic       r_increment;
  logic       r_decrement;
  logic       r_time_up;
  logic       r_busy;

  // A start_round re-targets immediately, so stepping on that edge already
  // heads toward the new value.
  assign w_target_new   = tens_target(ctl.level, MIN_TENS);
  assign w_target_eff   = ctl.start_round ? w_target_new : r_target;
  assign w_step_active  = (r_state == ST_ADJUST) && (r_shadow != w_target_eff);
  assign w_dir_up       = (w_target_eff > r_shadow);
  assign w_timeout_rise = ctl.timeout && !r_timeout_q;

  step_pacer #(
    .STEP_GAP (STEP_GAP)
  ) u_step_pacer (
    .clk       (clk),
    .rst       (rst),
    .active    (w_step_active),
    .dir_up    (w_dir_up),
    .inc_pulse (w_inc_pulse),
    .dec_pulse (w_dec_pulse)
  );

  // Shadow copy of the timer's tens start value and the latched target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= SCALE_RST;
      r_target    <= SCALE_RST;
      r_timeout_q <= 1'b0;
    end else begin
      r_timeout_q <= ctl.timeout;
      if (ctl.start_round) begin
        r_target <= w_target_new;
      end
      if (w_inc_pulse) begin
        r_shadow <= r_shadow + 4'd1;
      end else if (w_dec_pulse) begin
        r_shadow <= r_shadow - 4'd1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next output values; start_round beats round_done beats timeout.
  always_comb begin
    w_state_next   = r_state;
    w_time_up_next = 1'b0;
    if (ctl.start_round) begin
      w_state_next = ST_ADJUST;
    end else begin
      unique case (r_state)
        ST_ADJUST: begin
          if (r_shadow == r_target) begin
            w_state_next = ST_LOAD;
          end
        end
        ST_LOAD: begin
          w_state_next = ST_RUN;
        end
        ST_RUN: begin
          if (ctl.round_done) begin
            w_state_next = ST_IDLE;
          end else if (w_timeout_rise) begin
            w_state_next   = ST_IDLE;
            w_time_up_next = 1'b1;
          end
        end
        default: begin
          w_state_next = r_state;
        end
      endcase
    end
    w_reconfig_next = (w_state_next == ST_ADJUST) || (w_state_next == ST_LOAD);
    w_enable_next   = (w_state_next == ST_RUN);
    w_busy_next     = (w_state_next != ST_IDLE);
  end

  // Output registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reconfig  <= 1'b0;
      r_enable    <= 1'b0;
      r_increment <= 1'b0;
      r_decrement <= 1'b0;
      r_time_up   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_reconfig  <= w_reconfig_next;
      r_enable    <= w_enable_next;
      r_increment <= w_inc_pulse;
      r_decrement <= w_dec_pulse;
      r_time_up   <= w_time_up_next;
      r_busy      <= w_busy_next;
    end
  end

  assign ctl.ReConfig  = r_reconfig;
  assign ctl.enable    = r_enable;
  assign ctl.increment = r_increment;
  assign ctl.decrement = r_decrement;
  assign ctl.time_up   = r_time_up;
  assign ctl.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_round_timer_ctrl                                              |
// | Scoreboard bench: the driver pushes expected outputs from a      |
// | behavioural model, a monitor pops and compares each cycle.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_round_timer_ctrl;

  localparam int STEP_GAP = 2;
  localparam int MIN_TENS = 1;
  localparam int SCALE    = 9;

  logic clk = 1'b0;
  logic rst;

  round_timer_ctrl_if bus();

  round_timer_ctrl #(
    .SCALE_RST (4'(SCALE)),
    .MIN_TENS  (4'(MIN_TENS)),
    .STEP_GAP  (STEP_GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // mode: 0 waiting, 1 adjusting, 2 reloading, 3 round running
  int m_mode, m_shadow, m_target, m_wait;
  bit m_prev_to;

  function automatic int tens_for(input int lvl);
    if (lvl >= 9 - MIN_TENS) return MIN_TENS;
    return 9 - lvl;
  endfunction

  // Expected outputs {ReConfig, enable, increment, decrement, time_up, busy}
  // seen after the coming rising edge.
  task automatic model_edge(input bit r, input bit s, input bit d, input int lvl,
                            input bit tmo, output logic [5:0] e);
    bit inc, dec, tu;
    int eff, nm;
    inc = 0; dec = 0; tu = 0;
    if (r) begin
      m_mode = 0; m_shadow = SCALE; m_target = SCALE; m_wait = 0; m_prev_to = 0;
      e = '0;
      return;
    end
    eff = s ? tens_for(lvl) : m_target;
    nm  = m_mode;
    if (s) nm = 1;
    else if (m_mode == 1 && m_shadow == m_target) nm = 2;
    else if (m_mode == 2) nm = 3;
    else if (m_mode == 3 && d) nm = 0;
    else if (m_mode == 3 && tmo && !m_prev_to) begin nm = 0; tu = 1; end
    if (m_mode == 1 && m_shadow != eff) begin
      if (m_wait == 0) begin
        if (eff > m_shadow) begin inc = 1; m_shadow++; end
        else begin dec = 1; m_shadow--; end
        m_wait = STEP_GAP - 1;
      end else begin
        m_wait--;
      end
    end else begin
      m_wait = 0;
    end
    m_target  = eff;
    m_mode    = nm;
    m_prev_to = tmo;
    e = {(nm == 1 || nm == 2), (nm == 3), inc, dec, tu, (nm != 0)};
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [5:0] exp_q[$];
  bit  sb_on   = 0;
  int  cyc     = 0;
  int  obs_inc = 0;
  int  obs_dec = 0;
  int  obs_tu  = 0;
  int  dec_cyc[$];
  int  en_rise = -1;
  int  last_cyc = 0;

  function automatic logic [5:0] outs();
    return {bus.ReConfig, bus.enable, bus.increment, bus.decrement, bus.time_up, bus.busy};
  endfunction

  initial begin
    logic [5:0] e;
    logic       prev_en;
    prev_en = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("outputs@cycle%0d", cyc), int'(outs()), int'(e));
      end else if (sb_on) begin
        chk("scoreboard_underflow", 0, 1);
      end
      if (bus.increment) obs_inc++;
      if (bus.decrement) begin obs_dec++; dec_cyc.push_back(cyc); end
      if (bus.time_up) obs_tu++;
      if (bus.enable && !prev_en) en_rise = cyc;
      prev_en = bus.enable;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit s, input bit d, input int lvl, input bit tmo);
    logic [5:0] e;
    @(negedge clk);
    rst             = r;
    bus.start_round = s;
    bus.round_done  = d;
    bus.level       = 4'(lvl);
    bus.timeout     = tmo;
    model_edge(r, s, d, lvl, tmo, e);
    exp_q.push_back(e);
    sb_on    = 1;
    last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n, input bit tmo);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, tmo);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int st, b_inc, b_dec, b_tu, b_idx;
    bit tmo;
    rst = 1'b1;
    bus.start_round = 1'b0;
    bus.round_done  = 1'b0;
    bus.level       = 4'd0;
    bus.timeout     = 1'b0;
    m_mode = 0; m_shadow = SCALE; m_target = SCALE; m_wait = 0; m_prev_to = 0;

    // Reset state
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    settle();
    chk("reset_outputs", int'(outs()), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_shadow", int'(dut.r_shadow), SCALE);

    // Level 3 from shadow 9: three decrements two cycles apart
    drive(0, 0, 0, 0, 0);
    b_inc = obs_inc; b_dec = obs_dec; b_idx = dec_cyc.size();
    drive(0, 1, 0, 3, 0);
    st = last_cyc;
    idle(12, 0);
    settle();
    chk("l3_dec_count", obs_dec - b_dec, 3);
    chk("l3_inc_count", obs_inc - b_inc, 0);
    if (dec_cyc.size() - b_idx == 3) begin
      chk("l3_first_pulse_offset", dec_cyc[b_idx] - st, 1);
      chk("l3_pulse_gap1", dec_cyc[b_idx+1] - dec_cyc[b_idx], 2);
      chk("l3_pulse_gap2", dec_cyc[b_idx+2] - dec_cyc[b_idx+1], 2);
      chk("l3_enable_after_last", en_rise - dec_cyc[b_idx+2], 2);
    end
    chk("l3_running", int'(bus.enable), 1);

    // Timeout in RUN, then held high
    b_tu = obs_tu;
    idle(5, 1);
    settle();
    chk("timeout_time_up_count", obs_tu - b_tu, 1);
    chk("timeout_idle_busy", int'(bus.busy), 0);
    idle(2, 0);

    // Shadow 6, level 12 clamps to 1: five decrements
    b_inc = obs_inc; b_dec = obs_dec;
    drive(0, 1, 0, 12, 0);
    idle(16, 0);
    settle();
    chk("l12_dec_count", obs_dec - b_dec, 5);
    chk("l12_inc_count", obs_inc - b_inc, 0);
    chk("l12_shadow", int'(dut.r_shadow), MIN_TENS);
    chk("l12_running", int'(bus.enable), 1);

    // round_done and timeout rising together: no time_up
    b_tu = obs_tu;
    drive(0, 0, 1, 0, 1);
    idle(3, 1);
    settle();
    chk("done_vs_timeout_time_up", obs_tu - b_tu, 0);
    chk("done_vs_timeout_enable", int'(bus.enable), 0);
    idle(2, 0);

    // start_round together with round_done while running
    drive(0, 1, 0, 5, 0);
    idle(12, 0);
    drive(0, 1, 1, 5, 0);
    settle();
    chk("start_beats_done_reconfig", int'(bus.ReConfig), 1);
    chk("start_beats_done_busy", int'(bus.busy), 1);
    idle(4, 0);

    // Asynchronous reset mid-adjust
    drive(0, 1, 0, 0, 0);
    idle(3, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'(outs()), 0);
    chk("async_reset_shadow", int'(dut.r_shadow), SCALE);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    b_inc = obs_inc; b_dec = obs_dec;
    drive(0, 1, 0, 0, 0);
    st = last_cyc;
    idle(6, 0);
    settle();
    chk("l0_no_pulses", (obs_inc - b_inc) + (obs_dec - b_dec), 0);
    chk("l0_enable_offset", en_rise - st, 2);
    idle(2, 0);

    // Randomized traffic
    tmo = 0;
    for (int i = 0; i < 2500; i++) begin
      bit r, s, d;
      int lvl;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 24) == 0);
      d   = ($urandom_range(0, 29) == 0);
      lvl = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) tmo = !tmo;
      drive(r, s, d, lvl, tmo);
    end
    settle();
    chk("scoreboard_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
